// File: rtl/key_cmd_encoder.sv
// key_cmd_encoder: debounces a bank of raw key inputs, picks the highest-index
// pressed key and emits its command code once on press, then auto-repeats
// while held. Commands are held in a single-entry output register with a
// valid/ack handshake; commands arriving while that register is still full
// are discarded and flagged on a sticky dropped bit.
module key_cmd_encoder #(
  parameter int                    NKEYS           = 5,
  parameter int                    IW              = 4,
  parameter logic [NKEYS*IW-1:0]   CODE_MAP        = 20'h23145,
  parameter int                    DEBOUNCE_CYCLES = 16,
  parameter int                    REPEAT_EN       = 1,
  parameter int                    REPEAT_DELAY    = 50000000,
  parameter int                    REPEAT_PERIOD   = 10000000
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [NKEYS-1:0] keys,
  input  logic             cmd_ack,
  input  logic             drop_clr,
  output logic [NKEYS-1:0] key_state,
  output logic             cmd_valid,
  output logic [IW-1:0]    cmd,
  output logic             dropped
);

  localparam int KW   = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [NKEYS-1:0]         sync1, sync2;
  logic [NKEYS-1:0][DW-1:0] dcnt;
  state_t                   state;
  logic [RW-1:0]            rcnt;
  logic [KW-1:0]            act;
  logic [KW-1:0]            top;
  logic                     any;
  logic                     emit;
  logic [IW-1:0]            code;

  // Two-flop synchronizer on the raw key levels
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Per-key debounce: accept a new level only after it has disagreed with
  // the debounced level for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge sysclk) begin
    if (rst) begin
      dcnt      <= '0;
      key_state <= '0;
    end else begin
      for (int k = 0; k < NKEYS; k++) begin
        if (sync2[k] != key_state[k]) begin
          if (dcnt[k] == DB_LAST) begin
            key_state[k] <= sync2[k];
            dcnt[k]      <= '0;
          end else begin
            dcnt[k] <= dcnt[k] + 1'b1;
          end
        end else begin
          dcnt[k] <= '0;
        end
      end
    end
  end

  // Active key: highest-index debounced key, plus its command code
  always_comb begin
    any = |key_state;
    top = '0;
    for (int k = 0; k < NKEYS; k++)
      if (key_state[k]) top = KW'(k);
    code = CODE_MAP[int'(top)*IW +: IW];
  end

  // Emission decision for the current cycle
  always_comb begin
    emit = 1'b0;
    case (state)
      IDLE:    emit = any;
      DELAY:   emit = any && ((top != act) || (REPEAT_EN != 0 && rcnt == RD_LAST));
      REPEAT:  emit = any && ((top != act) || (rcnt == RP_LAST));
      default: emit = 1'b0;
    endcase
  end

  // Repeat FSM plus the single-entry command register and drop flag
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      rcnt      <= '0;
      act       <= '0;
      cmd_valid <= 1'b0;
      cmd       <= '0;
      dropped   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            act   <= top;
            rcnt  <= '0;
            state <= DELAY;
          end
        end
        DELAY: begin
          if (!any) begin
            state <= IDLE;
          end else if (top != act) begin
            act  <= top;
            rcnt <= '0;
          end else if (REPEAT_EN != 0 && rcnt == RD_LAST) begin
            rcnt  <= '0;
            state <= REPEAT;
          end else if (rcnt != RD_LAST) begin
            rcnt <= rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!any) begin
            state <= IDLE;
          end else if (top != act) begin
            act   <= top;
            rcnt  <= '0;
            state <= DELAY;
          end else if (rcnt == RP_LAST) begin
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A full register only takes a new command when it is acked this cycle
      if (emit) begin
        if (!cmd_valid || cmd_ack) begin
          cmd       <= code;
          cmd_valid <= 1'b1;
        end
      end else if (cmd_valid && cmd_ack) begin
        cmd_valid <= 1'b0;
        cmd       <= '0;
      end

      // A drop event beats a simultaneous clear
      if (emit && cmd_valid && !cmd_ack)
        dropped <= 1'b1;
      else if (drop_clr)
        dropped <= 1'b0;
    end
  end

endmodule
